// File: rtl/nios_cpu_debug_access_arbiter_pkg.sv
// Shared types and JTAG data-word field positions for the OCI RAM debug access arbiter.
package nios_cpu_debug_access_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } arb_state_e;

   typedef enum logic {
      GntSys,
      GntJtag
   } grant_e;

   localparam int unsigned JDO_W       = 38;
   localparam int unsigned JDO_ADDR_HI = 33;
   localparam int unsigned JDO_ADDR_LO = 26;
   localparam int unsigned JDO_RD_BIT  = 35;
   localparam int unsigned JDO_CLR_BIT = 37;
   localparam int unsigned JDO_WD_HI   = 34;
   localparam int unsigned JDO_WD_LO   = 3;

endpackage

// File: rtl/nios_cpu_debug_jtag_cmd_latch.sv
// JTAG ocimem pulse decode, one-deep pending command, JTAG address pointer and overrun tracking.
// Optional saturating drop counter built only when DBG_ARB_DROPCNT_EN is defined.
module nios_cpu_debug_jtag_cmd_latch
   import nios_cpu_debug_access_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              jtag_busy,
   input  logic              jtag_grant,
   input  logic              jaddr_inc,
   output logic              cmd_valid,
   output logic              cmd_read,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_wdata,
   output logic              pending,
   output logic              jtag_overrun,
   output logic [7:0]        drop_count
);

   logic              blocked, acc_a, acc_b, drop_a, drop_b, new_cmd, clr;
   logic [ADDR_W-1:0] jdo_addr, jaddr_q, jaddr_d;
   logic [DATA_W-1:0] jdo_wdata, pend_wdata_q, pend_wdata_d;
   logic              pend_q, pend_d, pend_read_q, pend_read_d;
   logic              overrun_q, overrun_d;
   logic              unused_jdo;

   assign jdo_addr   = ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
   assign jdo_wdata  = DATA_W'(jdo[JDO_WD_HI:JDO_WD_LO]);
   assign unused_jdo = ^{jdo[36], jdo[2:0]};

   // A pulse is refused while a command waits or a JTAG access is still running.
   always_comb begin
      blocked = pend_q | jtag_busy;
      acc_a   = take_action_ocimem_a & ~blocked;
      acc_b   = take_action_ocimem_b & ~take_action_ocimem_a & ~blocked;
      drop_a  = take_action_ocimem_a & blocked;
      drop_b  = take_action_ocimem_b & (take_action_ocimem_a | blocked);
      new_cmd = (acc_a & jdo[JDO_RD_BIT]) | acc_b;
      clr     = acc_a & jdo[JDO_CLR_BIT];
   end

   // Fresh commands bypass the pending register so an idle arbiter can grant them at once.
   assign cmd_valid    = pend_q | new_cmd;
   assign cmd_read     = pend_q ? pend_read_q : acc_a;
   assign cmd_addr     = acc_a ? jdo_addr : jaddr_q;
   assign cmd_wdata    = pend_q ? pend_wdata_q : jdo_wdata;
   assign pending      = pend_q;
   assign jtag_overrun = overrun_q;

   always_comb begin
      pend_d       = pend_q;
      pend_read_d  = pend_read_q;
      pend_wdata_d = pend_wdata_q;
      jaddr_d      = jaddr_q;
      overrun_d    = overrun_q;
      if (jtag_grant) begin
         pend_d = 1'b0;
      end else if (new_cmd) begin
         pend_d       = 1'b1;
         pend_read_d  = acc_a;
         pend_wdata_d = jdo_wdata;
      end
      if (acc_a) begin
         jaddr_d = jdo_addr;
      end else if (jaddr_inc) begin
         jaddr_d = jaddr_q + 1'b1;
      end
      if (clr) begin
         overrun_d = 1'b0;
      end
      if (drop_a | drop_b) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q       <= 1'b0;
         pend_read_q  <= 1'b0;
         pend_wdata_q <= '0;
         jaddr_q      <= '0;
         overrun_q    <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_read_q  <= pend_read_d;
         pend_wdata_q <= pend_wdata_d;
         jaddr_q      <= jaddr_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef DBG_ARB_DROPCNT_EN
   logic [7:0] dcnt_q, dcnt_d;
   logic [8:0] dcnt_sum;

   always_comb begin
      dcnt_d   = clr ? 8'd0 : dcnt_q;
      dcnt_sum = {1'b0, dcnt_d} + {8'd0, drop_a} + {8'd0, drop_b};
      dcnt_d   = dcnt_sum[8] ? 8'hFF : dcnt_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dcnt_q <= 8'd0;
      end else begin
         dcnt_q <= dcnt_d;
      end
   end

   assign drop_count = dcnt_q;
`else
   assign drop_count = 8'd0;
`endif

endmodule

// File: rtl/nios_cpu_debug_access_arbiter.sv
// Shares the single-port OCI RAM between JTAG debug commands and a system register port.
// Build option DBG_ARB_DROPCNT_EN enables the dropped-command counter on drop_count.
module nios_cpu_debug_access_arbiter
   import nios_cpu_debug_access_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              debugack,
   input  logic              sys_req,
   input  logic              sys_write,
   input  logic [ADDR_W-1:0] sys_addr,
   input  logic [DATA_W-1:0] sys_wdata,
   output logic              sys_ack,
   output logic [DATA_W-1:0] sys_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              jtag_overrun,
   output logic [7:0]        drop_count
);

   arb_state_e        state_q, state_d;
   grant_e            gnt_q, gnt_d, last_grant_q, last_grant_d;
   logic              op_read_q, op_read_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, sys_rdata_q, sys_rdata_d;
   logic [31:0]       mon_q, mon_d;
   logic              pick_jtag, jtag_grant, jtag_busy, jaddr_inc, pending;
   logic              cmd_valid, cmd_read;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   nios_cpu_debug_jtag_cmd_latch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmd_latch (
      .clk                  (clk),
      .reset                (reset),
      .jdo                  (jdo),
      .take_action_ocimem_a (take_action_ocimem_a),
      .take_action_ocimem_b (take_action_ocimem_b),
      .jtag_busy            (jtag_busy),
      .jtag_grant           (jtag_grant),
      .jaddr_inc            (jaddr_inc),
      .cmd_valid            (cmd_valid),
      .cmd_read             (cmd_read),
      .cmd_addr             (cmd_addr),
      .cmd_wdata            (cmd_wdata),
      .pending              (pending),
      .jtag_overrun         (jtag_overrun),
      .drop_count           (drop_count)
   );

   assign jtag_busy = (state_q != StIdle) && (gnt_q == GntJtag);
   assign jaddr_inc = (state_q == StDone) && (gnt_q == GntJtag);

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      op_read_d    = op_read_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      sys_rdata_d  = sys_rdata_q;
      mon_d        = mon_q;
      pick_jtag    = 1'b0;
      jtag_grant   = 1'b0;
      case (state_q)
         StIdle: begin
            if (cmd_valid || sys_req) begin
               // Halted CPU gives JTAG strict priority; otherwise alternate on contention.
               pick_jtag    = cmd_valid && (!sys_req || debugack || last_grant_q == GntSys);
               jtag_grant   = pick_jtag;
               gnt_d        = pick_jtag ? GntJtag : GntSys;
               last_grant_d = gnt_d;
               op_read_d    = pick_jtag ? cmd_read : !sys_write;
               addr_d       = pick_jtag ? cmd_addr : sys_addr;
               wdata_d      = pick_jtag ? cmd_wdata : sys_wdata;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            if (op_read_q) begin
               cnt_d   = 2'(RD_LAT - 1);
               state_d = StWait;
            end else begin
               state_d = StDone;
            end
         end
         StWait: begin
            if (cnt_q == 2'd0) begin
               if (gnt_q == GntSys) begin
                  sys_rdata_d = ram_rdata;
               end else begin
                  mon_d = 32'(ram_rdata);
               end
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         gnt_q        <= GntSys;
         last_grant_q <= GntSys;
         op_read_q    <= 1'b0;
         cnt_q        <= 2'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         sys_rdata_q  <= '0;
         mon_q        <= 32'd0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         op_read_q    <= op_read_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         sys_rdata_q  <= sys_rdata_d;
         mon_q        <= mon_d;
      end
   end

   assign ram_addr      = addr_q;
   assign ram_wdata     = wdata_q;
   assign ram_we        = (state_q == StIssue) && !op_read_q;
   assign ram_re        = (state_q == StIssue) && op_read_q;
   assign sys_ack       = (state_q == StDone) && (gnt_q == GntSys);
   assign sys_rdata     = sys_rdata_q;
   assign MonDReg       = mon_q;
   assign monitor_ready = !pending && !jtag_busy;

endmodule

// File: tb/tb_nios_cpu_debug_access_arbiter.sv
// Directed bench for the OCI RAM debug access arbiter with a behavioural RAM of latency RD_LAT.
module tb_nios_cpu_debug_access_arbiter;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_LAT = 1;

`ifdef DBG_ARB_DROPCNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [37:0]       jdo;
   logic              take_action_ocimem_a, take_action_ocimem_b, debugack;
   logic              sys_req, sys_write;
   logic [ADDR_W-1:0] sys_addr;
   logic [DATA_W-1:0] sys_wdata, sys_rdata;
   logic              sys_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic              ram_we, ram_re;
   logic [31:0]       MonDReg;
   logic              monitor_ready, jtag_overrun;
   logic [7:0]        drop_count;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mem     [256];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   logic [DATA_W-1:0] rd_tmp;

   always #5 clk = ~clk;

   nios_cpu_debug_access_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .jdo                  (jdo),
      .take_action_ocimem_a (take_action_ocimem_a),
      .take_action_ocimem_b (take_action_ocimem_b),
      .debugack             (debugack),
      .sys_req              (sys_req),
      .sys_write            (sys_write),
      .sys_addr             (sys_addr),
      .sys_wdata            (sys_wdata),
      .sys_ack              (sys_ack),
      .sys_rdata            (sys_rdata),
      .ram_addr             (ram_addr),
      .ram_wdata            (ram_wdata),
      .ram_we               (ram_we),
      .ram_re               (ram_re),
      .ram_rdata            (ram_rdata),
      .MonDReg              (MonDReg),
      .monitor_ready        (monitor_ready),
      .jtag_overrun         (jtag_overrun),
      .drop_count           (drop_count)
   );

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) rd_pipe[0] <= mem[ram_addr];
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign ram_rdata = rd_pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
      logic [37:0] v;
      v        = '0;
      v[37]    = clr;
      v[35]    = rd;
      v[33:26] = addr;
      return v;
   endfunction

   function automatic logic [37:0] mk_b(input logic [31:0] d);
      logic [37:0] v;
      v       = '0;
      v[34:3] = d;
      return v;
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!monitor_ready && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(monitor_ready), 32'd1);
   endtask

   task automatic sys_access(input string tag, input logic wr, input logic [7:0] a,
                             input logic [31:0] d, output logic [31:0] rd);
      int n = 0;
      sys_req = 1'b1; sys_write = wr; sys_addr = a; sys_wdata = d;
      tick();
      while (!sys_ack && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(sys_ack), 32'd1);
      rd = sys_rdata;
      sys_req = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; jdo = '0; take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
      debugack = 1'b0; sys_req = 1'b0; sys_write = 1'b0; sys_addr = '0; sys_wdata = '0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_sys_ack", 32'(sys_ack), 32'd0);
      check("rst_sys_rdata", sys_rdata, 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_re", 32'(ram_re), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", ram_wdata, 32'd0);
      check("rst_mon", MonDReg, 32'd0);
      check("rst_ready", 32'(monitor_ready), 32'd1);
      check("rst_overrun", 32'(jtag_overrun), 32'd0);
      check("rst_dropcnt", 32'(drop_count), 32'd0);

      // Preload RAM through the system port
      sys_access("pre_10", 1'b1, 8'h10, 32'hDEADBEEF, rd_tmp);
      sys_access("pre_20", 1'b1, 8'h20, 32'hCAFE0020, rd_tmp);
      check("pre_mem10", mem[8'h10], 32'hDEADBEEF);

      // JTAG read of 0x10
      jdo = mk_a(8'h10, 1'b1, 1'b0); take_action_ocimem_a = 1'b1;
      check("jrd_rdy_pulse", 32'(monitor_ready), 32'd1);
      tick(); take_action_ocimem_a = 1'b0; jdo = '0;
      check("jrd_re", 32'(ram_re), 32'd1);
      check("jrd_addr", 32'(ram_addr), 32'h10);
      check("jrd_rdy_low", 32'(monitor_ready), 32'd0);
      tick(); tick();
      check("jrd_mon", MonDReg, 32'hDEADBEEF);
      tick();
      check("jrd_rdy_back", 32'(monitor_ready), 32'd1);

      // JTAG write lands at the incremented address 0x11
      jdo = mk_b(32'h11223344); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      check("jwr_we", 32'(ram_we), 32'd1);
      check("jwr_addr", 32'(ram_addr), 32'h11);
      check("jwr_wdata", ram_wdata, 32'h11223344);
      wait_ready("jwr_ready");
      check("jwr_mem", mem[8'h11], 32'h11223344);
      check("jwr_mon_kept", MonDReg, 32'hDEADBEEF);

      // Address auto-increment wraps 0xFF -> 0x00
      jdo = mk_a(8'hFF, 1'b0, 1'b0); take_action_ocimem_a = 1'b1;
      tick(); take_action_ocimem_a = 1'b0;
      jdo = mk_b(32'h1); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      wait_ready("wrap_rdy1");
      jdo = mk_b(32'h2); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      wait_ready("wrap_rdy2");
      check("wrap_mem_ff", mem[8'hFF], 32'h1);
      check("wrap_mem_00", mem[8'h00], 32'h2);

      // System latency: write acks 2 cycles after request, read RD_LAT+2
      sys_req = 1'b1; sys_write = 1'b1; sys_addr = 8'h30; sys_wdata = 32'hA5A5A5A5;
      tick();
      check("swr_ack_c1", 32'(sys_ack), 32'd0);
      tick();
      check("swr_ack_c2", 32'(sys_ack), 32'd1);
      check("swr_rdata_kept", sys_rdata, 32'd0);
      sys_req = 1'b0;
      tick();
      check("swr_mem", mem[8'h30], 32'hA5A5A5A5);
      sys_req = 1'b1; sys_write = 1'b0; sys_addr = 8'h20;
      tick(); tick();
      check("srd_ack_c2", 32'(sys_ack), 32'd0);
      tick();
      check("srd_ack_c3", 32'(sys_ack), 32'd1);
      check("srd_rdata", sys_rdata, 32'hCAFE0020);
      sys_req = 1'b0;
      tick();

      // Contention, debugack=0, last grant SYS: JTAG first, then SYS
      sys_req = 1'b1; sys_write = 1'b0; sys_addr = 8'h20;
      jdo = mk_b(32'h55); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      check("rr_j_we", 32'(ram_we), 32'd1);
      check("rr_j_addr", 32'(ram_addr), 32'h01);
      tick();
      check("rr_j_noack", 32'(sys_ack), 32'd0);
      tick();
      check("rr_gap_re", 32'(ram_re), 32'd0);
      tick();
      check("rr_s_re", 32'(ram_re), 32'd1);
      check("rr_s_addr", 32'(ram_addr), 32'h20);
      tick(); tick();
      check("rr_s_ack", 32'(sys_ack), 32'd1);
      sys_req = 1'b0;
      tick();
      check("rr_mem_01", mem[8'h01], 32'h55);

      // JTAG-only access leaves last grant at JTAG; debugack then keeps JTAG ahead
      jdo = mk_b(32'h66); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      wait_ready("dbg_pre_rdy");
      debugack = 1'b1;
      sys_req = 1'b1; sys_write = 1'b1; sys_addr = 8'h31; sys_wdata = 32'h77;
      jdo = mk_b(32'h88); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      check("dbg_j_addr", 32'(ram_addr), 32'h03);
      check("dbg_j_wdata", ram_wdata, 32'h88);
      tick(); tick(); tick();
      check("dbg_s_addr", 32'(ram_addr), 32'h31);
      tick();
      check("dbg_s_ack", 32'(sys_ack), 32'd1);
      sys_req = 1'b0; debugack = 1'b0;
      tick();

      // Overrun: write pulse one cycle after a JTAG read is dropped
      jdo = mk_a(8'h10, 1'b1, 1'b0); take_action_ocimem_a = 1'b1;
      tick(); take_action_ocimem_a = 1'b0;
      jdo = mk_b(32'hBAD); take_action_ocimem_b = 1'b1;
      tick(); take_action_ocimem_b = 1'b0; jdo = '0;
      check("ovr_flag", 32'(jtag_overrun), 32'd1);
      check("ovr_cnt", 32'(drop_count), CntEn ? 32'd1 : 32'd0);
      wait_ready("ovr_rdy");
      jdo = mk_a(8'h40, 1'b0, 1'b1); take_action_ocimem_a = 1'b1;
      tick(); take_action_ocimem_a = 1'b0; jdo = '0;
      check("ovr_clr_flag", 32'(jtag_overrun), 32'd0);
      check("ovr_clr_cnt", 32'(drop_count), 32'd0);

      // Simultaneous a and b: b dropped each cycle, counter saturates
      jdo = mk_a(8'h40, 1'b0, 1'b0);
      take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
      tick();
      check("sim_cnt1", 32'(drop_count), CntEn ? 32'd1 : 32'd0);
      check("sim_flag", 32'(jtag_overrun), 32'd1);
      for (int i = 0; i < 299; i++) tick();
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; jdo = '0;
      tick();
      check("sim_sat", 32'(drop_count), CntEn ? 32'd255 : 32'd0);
      check("sim_rdy", 32'(monitor_ready), 32'd1);
      jdo = mk_a(8'h40, 1'b0, 1'b1); take_action_ocimem_a = 1'b1;
      tick(); take_action_ocimem_a = 1'b0; jdo = '0;
      check("sim_clr_cnt", 32'(drop_count), 32'd0);

      // Reset during WAIT abandons the read
      sys_req = 1'b1; sys_write = 1'b0; sys_addr = 8'h20;
      tick(); tick();
      reset = 1'b1; sys_req = 1'b0;
      tick();
      check("rw_ack", 32'(sys_ack), 32'd0);
      check("rw_re", 32'(ram_re), 32'd0);
      check("rw_we", 32'(ram_we), 32'd0);
      check("rw_rdy", 32'(monitor_ready), 32'd1);
      check("rw_rdata", sys_rdata, 32'd0);
      reset = 1'b0;
      sys_req = 1'b1; sys_write = 1'b1; sys_addr = 8'h32; sys_wdata = 32'h99;
      tick();
      check("rw_w_ack_c1", 32'(sys_ack), 32'd0);
      tick();
      check("rw_w_ack_c2", 32'(sys_ack), 32'd1);
      sys_req = 1'b0;
      tick();
      check("rw_w_mem", mem[8'h32], 32'h99);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nios_cpu_debug_access_arbiter.md
Name: nios_cpu_debug_access_arbiter

Overview:
Sequences and shares the CPU on-chip-debug memory (OCI RAM, single port) between two requesters. The first is the JTAG debug slave's sysclk-side command pulses (take_action_ocimem_a/b with jdo). The second is a system-side register port used by on-chip test software. It returns JTAG read data through MonDReg/monitor_ready and system read data through sys_rdata/sys_ack. It sits between the debug slave sysclk block and the OCI RAM.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, OCI RAM data width (fixed 32 for jdo field mapping)
RD_LAT, 1, OCI RAM read latency in cycles (1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
jdo  in  38  JTAG data from debug slave, valid with take_action pulses
take_action_ocimem_a  in  1  one-cycle pulse: JTAG address/read command
take_action_ocimem_b  in  1  one-cycle pulse: JTAG write-data command
debugack  in  1  CPU is halted in debug mode
sys_req  in  1  system request, held until sys_ack
sys_write  in  1  1=write, 0=read; stable while sys_req
sys_addr  in  ADDR_W  system word address
sys_wdata  in  DATA_W  system write data
sys_ack  out  1  one-cycle completion pulse
sys_rdata  out  DATA_W  read data, valid with sys_ack, held until next read
ram_addr  out  ADDR_W  OCI RAM address
ram_wdata  out  DATA_W  OCI RAM write data
ram_we  out  1  one-cycle write strobe
ram_re  out  1  one-cycle read strobe
ram_rdata  in  DATA_W  OCI RAM read data, RD_LAT cycles after ram_re
MonDReg  out  32  JTAG read-back register
monitor_ready  out  1  high when no JTAG command is pending or in flight
jtag_overrun  out  1  sticky: a JTAG command was dropped
drop_count  out  8  dropped JTAG command count (optional feature)

Behaviour:
- Reset: FSM=IDLE, jaddr=0, JTAG pending=0, last_grant=SYS.
  - Outputs: sys_ack=0, sys_rdata=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, MonDReg=0, monitor_ready=1, jtag_overrun=0, drop_count=0.
  - Reset mid-access abandons the access; strobes are low from the next edge.
- JTAG command decode (latched into a one-deep pending register):
  - ocimem_a: jaddr<=jdo[33:26]. If jdo[35]=1, queue a read at that address. If jdo[37]=1, clear jtag_overrun and drop_count.
  - ocimem_b: queue a write of jdo[34:3] at jaddr.
  - monitor_ready falls in the cycle after the pulse.
- Drops:
  - A pulse arriving while pending=1 or a JTAG access is in flight is dropped and sets jtag_overrun.
  - Simultaneous a and b: a is accepted; b is dropped and counted.
- Arbitration, evaluated in IDLE:
  - If debugack=1, JTAG has strict priority.
  - Otherwise round-robin using last_grant.
  - A single requester is granted immediately.
- FSM states: IDLE -> ISSUE -> (WAIT if read) -> DONE -> IDLE.
  - ISSUE: exactly one cycle; drives ram_addr/ram_wdata and asserts ram_we or ram_re.
  - WAIT: counter runs RD_LAT-1 cycles. ram_rdata is captured in the cycle RD_LAT after ISSUE.
  - DONE, SYS grant: sys_ack=1 for one cycle; sys_rdata is updated on reads.
  - DONE, JTAG grant: MonDReg is loaded on reads; jaddr <= jaddr+1, wrapping modulo 2^ADDR_W (255->0). monitor_ready rises the next cycle if nothing is pending.
- Latency, from the IDLE sample to sys_ack: write = 2 cycles; read = RD_LAT+2 cycles.
- Back-to-back grants: the next request is arbitrated in the IDLE cycle after DONE, so there is at least one idle cycle between strobes.
- sys_req deasserted before sys_ack is a protocol violation. The started access still completes and acks.
- Writes never change MonDReg or sys_rdata.

Optional Feature:
- Macro: DBG_ARB_DROPCNT_EN.
- Defined: drop_count is an 8-bit saturating counter (stops at 255) that increments once per dropped JTAG pulse, or by 2 when a and b are both dropped in the same cycle. It is cleared by reset or by ocimem_a with jdo[37]=1.
- Undefined: drop_count is tied to 0 and no counter logic is built. jtag_overrun behaviour is unchanged.

Decomposition:
- Shared package: FSM state enum (IDLE, ISSUE, WAIT, DONE); grant enum (GNT_SYS, GNT_JTAG); jdo field constants (JDO_ADDR_HI=33, JDO_ADDR_LO=26, JDO_RD_BIT=35, JDO_CLR_BIT=37, JDO_WD_HI=34, JDO_WD_LO=3).
- One natural sub-module, nios_cpu_debug_jtag_cmd_latch: pulse decode, pending register, overrun logic, drop counter.
- The arbiter/FSM stays in the top level.

Test Plan:
- JTAG read: ocimem_a with jdo[35]=1, address 0x10; RAM[0x10]=0xDEADBEEF; RD_LAT=1 -> ram_re high 1 cycle after the pulse; MonDReg=0xDEADBEEF 3 cycles after the pulse; jaddr=0x11; monitor_ready returns to 1.
- Auto-increment wrap: ocimem_a to address 0xFF, then two ocimem_b writes of 0x1 and 0x2 -> RAM[0xFF]=0x1 and RAM[0x00]=0x2.
- Contention: sys_req (read 0x20) and a JTAG write in the same cycle. debugack=0 with last_grant=SYS -> JTAG served first, then SYS. With debugack=1 and last_grant=JTAG -> JTAG still served first.
- Overrun: ocimem_a read, then ocimem_b 1 cycle later -> jtag_overrun=1 and drop_count=1; ocimem_a with jdo[37]=1 -> both cleared.
- Simultaneous a and b -> b dropped, drop_count+1. With 300 drops -> drop_count saturates at 255; with the macro undefined -> drop_count stays 0.
- Reset asserted during WAIT with RD_LAT=4 -> no sys_ack, strobes low, monitor_ready=1, FSM back in IDLE; a subsequent sys write acks 2 cycles after request.
